seg_bcd_scheduler: RTL and testbench
====================================

// Module: seg_bcd_scheduler
// PURPOSE
//   Shares one sequential shift-add-3 binary-to-BCD converter round-robin between the four CPU
//   output ports. Each port's low VAL_W bits become two registered decimal digits (tens/ones)
//   for the seven-segment decoders. Sits between the CPU I/O output ports and the one_digit decoders.
//   Replaces four combinational converters with one shared engine; a port is reconverted only when its value changes.
// PARAMETERS
//   VAL_W   8   converted bits per port, legal 4..8; max value 2^VAL_W-1 fits 3 BCD digits
//   NPORT   4   number of output ports served; fixed at 4 in this revision
// PORTS
//   clock      in   1    system clock; all state updates on posedge
//   reset      in   1    synchronous, active-high reset
//   out_port0  in   32   CPU output port 0 value; likewise out_port1..out_port3
//   force      in   1    1-cycle pulse: invalidate all ports, reconvert all four
//   dig_h      out  16   tens digits, port p at [4p+3:4p]
//   dig_l      out  16   ones digits, port p at [4p+3:4p]
//   dig_vld    out  4    port p digits reflect a completed conversion
//   ovf        out  4    port p value > 99 or port bits [31:VAL_W] nonzero
//   busy       out  1    converter in LOAD/SHIFT/STORE
//   done       out  1    1-cycle pulse in cycle after STORE writes a port
// BEHAVIOUR
//   Reset: dig_h=dig_l=0, dig_vld=0, ovf=0, busy=0, done=0, ptr=0, shadow[0..3]=0, state IDLE.
//   FSM: IDLE -> LOAD -> SHIFT (VAL_W cycles) -> STORE -> IDLE.
//   IDLE: port ptr needs work if !dig_vld[ptr] or out_port[ptr] != shadow[ptr] (all 32 bits).
//     Needs work -> LOAD. Else ptr <= ptr+1 mod 4, stay IDLE; one port checked per cycle.
//   LOAD: snapshot shadow[ptr] <= out_port[ptr]; acc <= {12'b0, out_port[ptr][VAL_W-1:0]}; cnt <= VAL_W.
//   SHIFT: per cycle, each BCD nibble >= 5 gets +3, then {bcd,bin} shifts left 1.
//     cnt decrements; exit to STORE when cnt reaches 1 at the edge.
//   STORE: hi = shadow[ptr][31:VAL_W] != 0 or hundreds nibble != 0.
//     hi=1 -> digits saturate to 9/9 and ovf[ptr]=1. Else tens/ones written, ovf[ptr]=0.
//     dig_vld[ptr]=1; ptr <= ptr+1 mod 4; done pulses next cycle.
//   Latency: change visible to IDLE at cycle t -> new digits on outputs after edge t+VAL_W+3.
//     Worst case, all four changed: 4*(VAL_W+3) cycles.
//   Port changes during a conversion: ignored; the snapshot is used. Mismatch caught on next visit to that port.
//   Port returns to its old value before its visit: no reconversion, no done pulse.
//   force: clears dig_vld[3:0] at that edge; digits and ovf hold their old values.
//     force in same cycle as STORE: force wins, dig_vld stays 0. The stored digits are still written.
//     An in-flight conversion is not aborted.
//   Reset mid-conversion: immediate return to reset state; the partial result is discarded.
//   After reset, all four ports convert once (dig_vld=0), in order 0,1,2,3.
//   busy=1 exactly in LOAD, SHIFT and STORE. Outputs change only in STORE; glitch-free register outputs.
// STRUCTURE
//   Shared package display_pkg: FSM state enum (IDLE/LOAD/SHIFT/STORE), BCD_DIGITS=3, NIB_W=4, SAT_DIGIT=4'd9.
//   Sub-module bcd_add3_shift: combinational single step; {12-bit bcd, VAL_W bin} in -> shifted out.
//   Everything else is in this module: FSM, ptr, cnt, shadow regs, digit regs.
// TESTING
//   1. Reset, ports=0,5,42,99 -> done x4 in port order. dig_h/dig_l = 0/0,0/5,4/2,9/9. ovf=0, dig_vld=4'hF.
//   2. Steady state, port2 42->73 -> within VAL_W+3+4 cycles port2 = 7/3, one done pulse, other ports unchanged.
//   3. port1=150 -> 9/9, ovf[1]=1. Then port1=32'h100_0007 -> 9/9, ovf[1]=1. Then port1=7 -> 0/7, ovf[1]=0.
//   4. port0 changes 10->20 mid-SHIFT -> first result 1/0, then second conversion gives 2/0. Exactly two done pulses.
//   5. force asserted on the STORE cycle -> dig_vld=0, then all four reconvert; done count = 5 including the in-flight one.
//   6. Reset asserted mid-SHIFT -> next cycle all outputs 0, busy=0, ptr=0. Reconversion restarts at port 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
package display_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_e;

  localparam int BCD_DIGITS = 3;
  localparam int NIB_W      = 4;
  localparam int BCD_W      = BCD_DIGITS * NIB_W;
  localparam logic [NIB_W-1:0] SAT_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_add3_shift.sv
// One step of the shift-add-3 (double dabble) binary-to-BCD conversion.
// Layout of the accumulator: {hundreds, tens, ones, binary[VAL_W-1:0]}.
module bcd_add3_shift
  import display_pkg::*;
#(
  parameter int VAL_W = 8
) (
  input  logic [BCD_W+VAL_W-1:0] acc_i,
  output logic [BCD_W+VAL_W-1:0] acc_o
);
  logic [BCD_W+VAL_W-1:0] adj;

  // Correct every BCD nibble that would overflow past 9 after doubling, then shift.
  always_comb begin
    adj = acc_i;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (acc_i[VAL_W + d*NIB_W +: NIB_W] >= 4'd5)
        adj[VAL_W + d*NIB_W +: NIB_W] = acc_i[VAL_W + d*NIB_W +: NIB_W] + 4'd3;
    end
    acc_o = adj << 1;
  end
endmodule

// File: rtl/seg_bcd_scheduler.sv
// Round-robin scheduler sharing one sequential BCD converter across four
// CPU output ports. A port is reconverted only when its 32-bit value differs
// from the snapshot taken at its last conversion, or when it has been
// invalidated (reset / force_in).
module seg_bcd_scheduler
  import display_pkg::*;
#(
  parameter int VAL_W = 8,
  parameter int NPORT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  input  logic [31:0] out_port3,
  input  logic        force_in,
  output logic [15:0] dig_h,
  output logic [15:0] dig_l,
  output logic [3:0]  dig_vld,
  output logic [3:0]  ovf,
  output logic        busy,
  output logic        done
);
  localparam int ACC_W = BCD_W + VAL_W;
  localparam logic [3:0] CNT_INIT = 4'(VAL_W);

  logic [NPORT-1:0][31:0] port_w;
  assign port_w = {out_port3, out_port2, out_port1, out_port0};

  state_e                    state_q, state_d;
  logic [1:0]                ptr_q, ptr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [ACC_W-1:0]          acc_q, acc_d, acc_step;
  logic [NPORT-1:0][31:0]    shadow_q, shadow_d;
  logic [NPORT-1:0][NIB_W-1:0] dig_h_q, dig_h_d, dig_l_q, dig_l_d;
  logic [NPORT-1:0]          vld_q, vld_d, ovf_q, ovf_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      need_work, hi;

  bcd_add3_shift #(.VAL_W(VAL_W)) u_step (
    .acc_i (acc_q),
    .acc_o (acc_step)
  );

  assign need_work = !vld_q[ptr_q] || (port_w[ptr_q] != shadow_q[ptr_q]);
  // Out of two-digit range: truncated high port bits or a hundreds digit.
  assign hi = (|shadow_q[ptr_q][31:VAL_W]) ||
              (acc_q[VAL_W + 2*NIB_W +: NIB_W] != '0);

  // Next-state, datapath and output register updates.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    dig_h_d  = dig_h_q;
    dig_l_d  = dig_l_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (need_work) state_d = LOAD;
        else           ptr_d   = ptr_q + 2'd1;
      end
      LOAD: begin
        shadow_d[ptr_q] = port_w[ptr_q];
        acc_d           = ACC_W'(port_w[ptr_q][VAL_W-1:0]);
        cnt_d           = CNT_INIT;
        state_d         = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = STORE;
      end
      STORE: begin
        if (hi) begin
          dig_h_d[ptr_q] = SAT_DIGIT;
          dig_l_d[ptr_q] = SAT_DIGIT;
          ovf_d[ptr_q]   = 1'b1;
        end else begin
          dig_h_d[ptr_q] = acc_q[VAL_W + NIB_W +: NIB_W];
          dig_l_d[ptr_q] = acc_q[VAL_W +: NIB_W];
          ovf_d[ptr_q]   = 1'b0;
        end
        vld_d[ptr_q] = 1'b1;
        ptr_d        = ptr_q + 2'd1;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // force_in overrides a same-cycle STORE valid; the digits still land.
    if (force_in) vld_d = '0;
    busy_d = (state_d != IDLE);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      dig_h_q  <= '0;
      dig_l_q  <= '0;
      vld_q    <= '0;
      ovf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      dig_h_q  <= dig_h_d;
      dig_l_q  <= dig_l_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dig_h   = dig_h_q;
  assign dig_l   = dig_l_q;
  assign dig_vld = vld_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_seg_bcd_scheduler.sv
// Directed bench for seg_bcd_scheduler (VAL_W=8).
module tb_seg_bcd_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] p0, p1, p2, p3;
  logic        force_in;
  logic [15:0] dig_h, dig_l;
  logic [3:0]  dig_vld, ovf;
  logic        busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [3:0] vld_log [0:63];

  always #5 clock = ~clock;

  seg_bcd_scheduler #(.VAL_W(8), .NPORT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_port0 (p0),
    .out_port1 (p1),
    .out_port2 (p2),
    .out_port3 (p3),
    .force_in  (force_in),
    .dig_h     (dig_h),
    .dig_l     (dig_l),
    .dig_vld   (dig_vld),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done)
  );

  // Count done pulses and log which ports were valid at each one.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (done_cnt < 64) vld_log[done_cnt] = dig_vld;
      done_cnt++;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd1);
  endtask

  initial begin
    int base;
    p0 = 32'd0; p1 = 32'd5; p2 = 32'd42; p3 = 32'd99;
    force_in = 1'b0;
    reset = 1'b1;
    repeat (3) step();

    // 1: reset state, then first conversion of all four ports in order
    chk("rst_dig_h", 32'(dig_h), 32'h0);
    chk("rst_dig_l", 32'(dig_l), 32'h0);
    chk("rst_vld", 32'(dig_vld), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    wait_done("t1_done4", 4, 60);
    repeat (2) step();
    chk("t1_dig_h", 32'(dig_h), 32'h9400);
    chk("t1_dig_l", 32'(dig_l), 32'h9250);
    chk("t1_vld", 32'(dig_vld), 32'hF);
    chk("t1_ovf", 32'(ovf), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_order0", 32'(vld_log[0]), 32'h1);
    chk("t1_order1", 32'(vld_log[1]), 32'h3);
    chk("t1_order2", 32'(vld_log[2]), 32'h7);
    chk("t1_order3", 32'(vld_log[3]), 32'hF);

    // 2: single port change in steady state
    base = done_cnt;
    p2 = 32'd73;
    wait_done("t2_done", base + 1, 20);
    repeat (30) step();
    chk("t2_one_done", 32'(done_cnt), 32'(base + 1));
    chk("t2_dig_h", 32'(dig_h), 32'h9700);
    chk("t2_dig_l", 32'(dig_l), 32'h9350);

    // 3: overflow by value and by high bits, then back in range
    base = done_cnt;
    p1 = 32'd150;
    wait_done("t3_done_a", base + 1, 20);
    repeat (2) step();
    chk("t3a_dig_h", 32'(dig_h), 32'h9790);
    chk("t3a_dig_l", 32'(dig_l), 32'h9390);
    chk("t3a_ovf", 32'(ovf), 32'h2);
    p1 = 32'h0100_0007;
    wait_done("t3_done_b", base + 2, 20);
    repeat (2) step();
    chk("t3b_dig_h", 32'(dig_h), 32'h9790);
    chk("t3b_dig_l", 32'(dig_l), 32'h9390);
    chk("t3b_ovf", 32'(ovf), 32'h2);
    p1 = 32'd7;
    wait_done("t3_done_c", base + 3, 20);
    repeat (2) step();
    chk("t3c_dig_h", 32'(dig_h), 32'h9700);
    chk("t3c_dig_l", 32'(dig_l), 32'h9370);
    chk("t3c_ovf", 32'(ovf), 32'h0);

    // 4: port changes mid-SHIFT; snapshot used, then reconverted
    repeat (5) step();
    base = done_cnt;
    p0 = 32'd10;
    wait_busy("t4_busy", 10);
    repeat (3) step();
    p0 = 32'd20;
    wait_done("t4_done_a", base + 1, 20);
    chk("t4a_p0", {28'h0, dig_h[3:0], dig_l[3:0]} >> 0, {28'h0, 8'h10} >> 0);
    wait_done("t4_done_b", base + 2, 20);
    chk("t4b_p0", 32'({dig_h[3:0], dig_l[3:0]}), 32'h20);
    repeat (30) step();
    chk("t4_two_done", 32'(done_cnt), 32'(base + 2));

    // 5: force on the STORE cycle of an in-flight conversion
    base = done_cnt;
    p3 = 32'd55;
    wait_busy("t5_busy", 10);
    repeat (9) step();
    force_in = 1'b1;
    step();
    force_in = 1'b0;
    chk("t5_vld_clr", 32'(dig_vld), 32'h0);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_p3_written", 32'({dig_h[15:12], dig_l[15:12]}), 32'h55);
    wait_done("t5_done5", base + 5, 60);
    repeat (30) step();
    chk("t5_done_total", 32'(done_cnt), 32'(base + 5));
    chk("t5_dig_h", 32'(dig_h), 32'h5702);
    chk("t5_dig_l", 32'(dig_l), 32'h5370);
    chk("t5_vld", 32'(dig_vld), 32'hF);
    chk("t5_ovf", 32'(ovf), 32'h0);

    // 6: reset mid-SHIFT, then full reconversion from port 0
    p2 = 32'd88;
    wait_busy("t6_busy", 10);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("t6_dig_h", 32'(dig_h), 32'h0);
    chk("t6_dig_l", 32'(dig_l), 32'h0);
    chk("t6_vld", 32'(dig_vld), 32'h0);
    chk("t6_ovf", 32'(ovf), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_done", 32'(done), 32'h0);
    reset = 1'b0;
    base = done_cnt;
    wait_done("t6_done4", base + 4, 60);
    repeat (2) step();
    chk("t6_order0", 32'(vld_log[base]), 32'h1);
    chk("t6_order1", 32'(vld_log[base + 1]), 32'h3);
    chk("t6_order2", 32'(vld_log[base + 2]), 32'h7);
    chk("t6_order3", 32'(vld_log[base + 3]), 32'hF);
    chk("t6_fin_dig_h", 32'(dig_h), 32'h5802);
    chk("t6_fin_dig_l", 32'(dig_l), 32'h5870);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
